gate_equiv_sequencer: RTL

//  Sequences an exhaustive truth-table sweep over two implementations of a
//  2-input gate (gate-level and expression forms) driven from the same inputs.

---
 rtl/gate_equiv_sequencer_pkg.sv | 19 +
 rtl/gate_equiv_sequencer_if.sv | 32 +++
 rtl/gate_equiv_sequencer_nor_golden.sv | 11 +
 rtl/gate_equiv_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/gate_equiv_sequencer_pkg.sv
// Shared types and helpers for the gate equivalence sequencer.
//   state_t : sweep FSM state encoding
//   cnt_w() : width of the settle-window counter for a given SETTLE
package gate_equiv_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Counter only has to reach SETTLE-1; keep at least one bit.
    function automatic int unsigned cnt_w(input int unsigned settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/gate_equiv_sequencer_if.sv
// Control/observation bundle between the sweep controller and the gate pair.
//   start, chk_golden : sweep request and golden-compare enable
//   a_i, b_i          : outputs of the two gate implementations
//   x_o               : vector driven to both implementations
//   busy, done, pass, err_cnt, fail_valid, fail_vec : sweep status
// master = bench/top side, slave = sequencer side.
interface gate_equiv_sequencer_if #(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned ERR_W = 3
);
    logic              start;
    logic              chk_golden;
    logic              a_i;
    logic              b_i;
    logic [N_IN-1:0]   x_o;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_cnt;
    logic              fail_valid;
    logic [N_IN-1:0]   fail_vec;

    modport master (
        output start, chk_golden, a_i, b_i,
        input  x_o, busy, done, pass, err_cnt, fail_valid, fail_vec
    );

    modport slave (
        input  start, chk_golden, a_i, b_i,
        output x_o, busy, done, pass, err_cnt, fail_valid, fail_vec
    );
endinterface

// File: rtl/gate_equiv_sequencer_nor_golden.sv
// Golden reference for the gate under test: N_IN-input NOR.
//   x   : input vector
//   y_c : ~|x (combinational)
module nor_golden #(
    parameter int unsigned N_IN = 2
) (
    input  logic [N_IN-1:0] x,
    output logic            y_c
);
    assign y_c = ~|x;
endmodule

// File: rtl/gate_equiv_sequencer.sv
// Exhaustive truth-table sweep comparing two gate implementations against
// each other and optionally against a NOR golden model.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of gate_equiv_sequencer_if (start/chk_golden in,
//                a_i/b_i from the gates, x_o to the gates, status outputs)
module gate_equiv_sequencer
    import gate_equiv_sequencer_pkg::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned ERR_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    gate_equiv_sequencer_if.slave bus
);

    localparam int unsigned      CNT_W   = cnt_w(SETTLE);
    localparam logic [N_IN-1:0]  X_LAST  = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(SETTLE - 1);

    state_t            state;
    logic [N_IN-1:0]   x;
    logic [CNT_W-1:0]  cnt;
    logic              gold;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err;
    logic              fail_valid;
    logic [N_IN-1:0]   fail_vec;

    logic              g_c;
    logic              mism_c;
    logic [ERR_W-1:0]  err_nxt_c;

    nor_golden #(.N_IN(N_IN)) u_nor_golden (
        .x   (x),
        .y_c (g_c)
    );

    // Only consumed in SAMPLE, so a_i/b_i glitches elsewhere are harmless.
    assign mism_c    = (bus.a_i != bus.b_i)
                     | (gold & ((bus.a_i != g_c) | (bus.b_i != g_c)));
    assign err_nxt_c = (mism_c && (err != ERR_MAX)) ? err + ERR_W'(1) : err;

    // Sweep FSM with registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            x          <= '0;
            cnt        <= '0;
            gold       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err        <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state      <= S_DRIVE;
                        x          <= '0;
                        err        <= '0;
                        fail_valid <= 1'b0;
                        fail_vec   <= '0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        gold       <= bus.chk_golden;
                    end
                end
                S_DRIVE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == CNT_END) begin
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    err <= err_nxt_c;
                    if (mism_c && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= x;
                    end
                    // Last vector: x stays put so it is visible after the sweep.
                    if (x == X_LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        pass  <= (err_nxt_c == '0);
                    end else begin
                        x     <= x + N_IN'(1);
                        state <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.x_o        = x;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.pass       = pass;
    assign bus.err_cnt    = err;
    assign bus.fail_valid = fail_valid;
    assign bus.fail_vec   = fail_vec;

endmodule
